// File: rtl/store_align_if.sv
// Store request and data-memory write-beat bundle for store_align_unit.
// The slave modport is the alignment unit; the master modport is the core/memory side.
interface store_align_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        funct3M;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  logic              done;
  logic              fault;

  modport slave (
    input  req_valid, funct3M, addr, wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
  );

  modport master (
    output req_valid, funct3M, addr, wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
  );
endinterface

// File: rtl/store_align_unit.sv
// Turns a (funct3M, address, rs2) store into one or two word-aligned write beats
// with lane-shifted data and byte strobes; word-crossing stores split or fault.
module store_align_unit #(
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  store_align_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       hi_wdata_q, hi_wdata_d;
  logic [3:0]        hi_wstrb_q, hi_wstrb_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic        size_ok;
  logic [3:0]  size_mask;
  logic [31:0] data_mask;
  logic [1:0]  off;
  logic [7:0]  strb8;
  logic [63:0] data64;
  logic        crosses;
  logic        reject;
  logic        accept;
  logic        beat_hs;

  // Lane placement in a 64-bit window spanning the addressed word and the next one.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    size_ok   = 1'b1;
    size_mask = 4'h0;
    data_mask = 32'h0000_0000;
    case (bus.funct3M)
      3'b000:  begin size_mask = 4'h1; data_mask = 32'h0000_00FF; end
      3'b001:  begin size_mask = 4'h3; data_mask = 32'h0000_FFFF; end
      3'b010:  begin size_mask = 4'hF; data_mask = 32'hFFFF_FFFF; end
      default: size_ok = 1'b0;
    endcase
    off     = bus.addr[1:0];
    strb8   = {4'b0000, size_mask} << off;
    data64  = {32'h0000_0000, bus.wdata & data_mask} << {off, 3'b000};
    crosses = |strb8[7:4];
    reject  = !size_ok || (crosses && !SPLIT_MISALIGNED);
  end

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign beat_hs = mem_valid_q && bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    hi_wdata_d  = hi_wdata_q;
    hi_wstrb_d  = hi_wstrb_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            fault_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = data64[31:0];
            mem_wstrb_d = strb8[3:0];
            hi_wdata_d  = data64[63:32];
            hi_wstrb_d  = strb8[7:4];
          end
        end
      end

      BEAT0: begin
        if (beat_hs) begin
          if (hi_wstrb_q == 4'h0) begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            // Second beat follows with no bubble; the address wraps at the top of memory.
            state_d     = BEAT1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_wdata_d = hi_wdata_q;
            mem_wstrb_d = hi_wstrb_q;
          end
        end
      end

      BEAT1: begin
        if (beat_hs) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_wstrb_q <= 4'h0;
      hi_wdata_q  <= 32'h0000_0000;
      hi_wstrb_q  <= 4'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_wstrb_q  <= hi_wstrb_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

  a_done_fault_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && fault_q));

  a_beat_hold: assert property (@(posedge clk) disable iff (!rst_n)
    mem_valid_q && !bus.mem_ready |=>
      mem_valid_q && $stable(mem_addr_q) && $stable(mem_wdata_q) && $stable(mem_wstrb_q));

  a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
    mem_valid_q |-> state_q != IDLE);

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit: vector table plus beat scoreboard,
// with hand-written backpressure, throughput, reset and no-split sequences.
module tb_store_align_unit;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_align_if #(.ADDR_W(ADDR_W)) bus ();
  store_align_if #(.ADDR_W(ADDR_W)) bus_ns ();

  store_align_unit #(.ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  store_align_unit #(.ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .bus(bus_ns)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbeats;
    bit          fault;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  vec_t  vecs[12];
  beat_t beat_q[$];
  bit    end_q[$];   // 1: done expected, 0: fault expected

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_hs = 0;
  int    done_cyc = 0;
  bit    mon_en = 1'b0;
  bit    held = 1'b0;
  beat_t prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (held) begin
        check("hold_valid", bus.mem_valid, 1);
        check("hold_addr", bus.mem_addr, prev.addr);
        check("hold_data", bus.mem_wdata, prev.data);
        check("hold_strb", bus.mem_wstrb, prev.strb);
      end
      held      <= bus.mem_valid && !bus.mem_ready;
      prev.addr <= bus.mem_addr;
      prev.data <= bus.mem_wdata;
      prev.strb <= bus.mem_wstrb;
      if (bus.mem_valid) check("busy_req_ready", bus.req_ready, 0);
      if (bus.mem_valid && bus.mem_ready) begin
        if (beat_q.size() == 0) begin
          fail("unexpected_beat", $sformatf("got beat at %h, expected none", bus.mem_addr));
        end else begin
          check("beat_addr", bus.mem_addr, beat_q[0].addr);
          check("beat_data", bus.mem_wdata, beat_q[0].data);
          check("beat_strb", bus.mem_wstrb, beat_q[0].strb);
          void'(beat_q.pop_front());
        end
        last_hs <= cyc;
      end
      if (bus.done && bus.fault) fail("done_and_fault", "got both high, expected at most one");
      if (bus.done || bus.fault) begin
        if (end_q.size() == 0) begin
          fail("unexpected_end", $sformatf("got done=%b fault=%b, expected neither", bus.done, bus.fault));
        end else begin
          check("end_kind_done", bus.done, end_q[0]);
          if (bus.done) begin
            check("done_latency", cyc, last_hs + 1);
            check("done_beats_left", beat_q.size(), 0);
            done_cyc <= cyc;
          end
          void'(end_q.pop_front());
        end
      end
    end else begin
      held <= 1'b0;
    end
  end

  // Drive a request, wait for acceptance, and push what the DUT should produce.
  task automatic issue(input vec_t v, output int acc_cyc);
    int budget;
    budget = 0;
    acc_cyc = -1;
    bus.funct3M   = v.f3;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.req_ready) begin
      fail("req_ready_timeout", "got req_ready=0 for 20 cycles, expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    if (v.fault) begin
      end_q.push_back(1'b0);
    end else begin
      beat_q.push_back('{addr: v.a0, data: v.d0, strb: v.s0});
      if (v.nbeats == 2) beat_q.push_back('{addr: v.a1, data: v.d1, strb: v.s1});
      end_q.push_back(1'b1);
    end
    check("accept_fault", bus.fault, v.fault);
    check("accept_valid", bus.mem_valid, !v.fault);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((beat_q.size() != 0 || end_q.size() != 0) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (beat_q.size() != 0 || end_q.size() != 0) begin
      fail("completion_timeout", $sformatf("got %0d beats/%0d ends pending, expected 0",
                                           beat_q.size(), end_q.size()));
      beat_q.delete();
      end_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, c;

    vecs[0]  = '{3'b000, 32'h0000_1003, 32'hFFFF_FFA5, 1, 1'b0,
                 32'h0000_1000, 32'hA500_0000, 4'b1000, 32'h0, 32'h0, 4'h0};
    vecs[1]  = '{3'b001, 32'h0000_2002, 32'hABCD_1234, 1, 1'b0,
                 32'h0000_2000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'h0};
    vecs[2]  = '{3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 2, 1'b0,
                 32'h0000_3000, 32'hADBE_EF00, 4'b1110, 32'h0000_3004, 32'h0000_00DE, 4'b0001};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 2, 1'b0,
                 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 32'h0000_0000, 32'h0000_1122, 4'b0011};
    vecs[4]  = '{3'b000, 32'h0000_0000, 32'h1234_5678, 1, 1'b0,
                 32'h0000_0000, 32'h0000_0078, 4'b0001, 32'h0, 32'h0, 4'h0};
    vecs[5]  = '{3'b001, 32'h0000_5003, 32'hFFFF_8001, 2, 1'b0,
                 32'h0000_5000, 32'h0100_0000, 4'b1000, 32'h0000_5004, 32'h0000_0080, 4'b0001};
    vecs[6]  = '{3'b010, 32'h0000_6000, 32'hCAFE_F00D, 1, 1'b0,
                 32'h0000_6000, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[7]  = '{3'b001, 32'h0000_7001, 32'h0000_BEEF, 1, 1'b0,
                 32'h0000_7000, 32'h00BE_EF00, 4'b0110, 32'h0, 32'h0, 4'h0};
    vecs[8]  = '{3'b011, 32'h0000_9000, 32'h5555_5555, 0, 1'b1,
                 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[9]  = '{3'b100, 32'h0000_9004, 32'h6666_6666, 0, 1'b1,
                 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[10] = '{3'b111, 32'h0000_9008, 32'h7777_7777, 0, 1'b1,
                 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[11] = '{3'b000, 32'h0000_8002, 32'h0000_00C3, 1, 1'b0,
                 32'h0000_8000, 32'h00C3_0000, 4'b0100, 32'h0, 32'h0, 4'h0};

    bus.req_valid = 1'b0; bus.funct3M = 3'b000; bus.addr = '0; bus.wdata = '0; bus.mem_ready = 1'b1;
    bus_ns.req_valid = 1'b0; bus_ns.funct3M = 3'b000; bus_ns.addr = '0; bus_ns.wdata = '0;
    bus_ns.mem_ready = 1'b1;

    // Reset state
    #12;
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wstrb", bus.mem_wstrb, 0);
    check("rst_req_ready", bus.req_ready, 1);
    #10 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table-driven single stores
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], a);
      wait_idle();
      if (!vecs[i].fault) check($sformatf("store_latency_%0d", i), done_cyc - a, vecs[i].nbeats);
      @(posedge clk); #1;
    end

    // Back-to-back requests: 2 cycles after a 1-beat store, 3 after a 2-beat store
    issue(vecs[0], a);
    issue(vecs[2], b);
    issue(vecs[4], c);
    wait_idle();
    check("spacing_1beat", b - a, 2);
    check("spacing_2beat", c - b, 3);

    // Backpressure on beat0 for three cycles
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    issue(vecs[2], a);
    repeat (3) begin
      check("stall_req_ready", bus.req_ready, 0);
      check("stall_valid", bus.mem_valid, 1);
      check("stall_addr", bus.mem_addr, 32'h0000_3000);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    wait_idle();
    check("stall_store_latency", done_cyc - a, 5);

    // Reset while beat1 is pending
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    issue(vecs[2], a);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    check("rst_mid_beat1_addr", bus.mem_addr, 32'h0000_3004);
    check("rst_mid_beat1_valid", bus.mem_valid, 1);
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_drop", bus.mem_valid, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_req_ready", bus.req_ready, 1);
    beat_q.delete();
    end_q.delete();
    @(posedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    mon_en = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_valid", bus.mem_valid, 0);
      check("post_rst_done", bus.done, 0);
    end
    check("post_rst_req_ready", bus.req_ready, 1);

    // Unit with splitting disabled: word-crossing half faults, aligned word still stores
    bus_ns.funct3M = 3'b001; bus_ns.addr = 32'h0000_4003; bus_ns.wdata = 32'h0000_BBAA;
    bus_ns.req_valid = 1'b1;
    check("ns_req_ready", bus_ns.req_ready, 1);
    @(posedge clk); #1;
    bus_ns.req_valid = 1'b0;
    check("ns_fault", bus_ns.fault, 1);
    check("ns_no_beat", bus_ns.mem_valid, 0);
    @(posedge clk); #1;
    check("ns_fault_pulse", bus_ns.fault, 0);
    check("ns_no_beat_later", bus_ns.mem_valid, 0);
    bus_ns.funct3M = 3'b010; bus_ns.addr = 32'h0000_4000; bus_ns.wdata = 32'h8765_4321;
    bus_ns.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_ns.req_valid = 1'b0;
    check("ns_word_valid", bus_ns.mem_valid, 1);
    check("ns_word_fault", bus_ns.fault, 0);
    check("ns_word_addr", bus_ns.mem_addr, 32'h0000_4000);
    check("ns_word_data", bus_ns.mem_wdata, 32'h8765_4321);
    check("ns_word_strb", bus_ns.mem_wstrb, 4'b1111);
    @(posedge clk); #1;
    check("ns_word_done", bus_ns.done, 1);
    check("ns_word_valid_drop", bus_ns.mem_valid, 0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
